// File: rtl/alu_shift_iter.sv
// Iterative 32-bit shifter/rotator: applies one 1-bit step per clock.
// Handshakes a request in IDLE and runs for B[4:0] cycles.
// Holds the result in DONE until the consumer takes it.
module alu_shift_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSar  = 4'b0110;
  localparam logic [3:0] OpRotl = 4'b0111;
  localparam logic [3:0] OpRotr = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e      r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_count;
  logic [3:0]  r_op;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_result;

  logic [31:0] w_step;
  logic        w_op_valid;
  logic        w_unused;

  // Only the low five bits of the shift amount matter.
  assign w_unused = ^B[31:5];

  // Decode whether the incoming opcode is one of the five supported operations.
  always_comb begin
    w_op_valid = 1'b0;
    case (opcode)
      OpSll, OpSar, OpRotl, OpRotr, OpSrl: w_op_valid = 1'b1;
      default:                             w_op_valid = 1'b0;
    endcase
  end

  // One 1-bit step of the stored operation applied to the accumulator.
  always_comb begin
    w_step = r_acc;
    case (r_op)
      OpSll:   w_step = {r_acc[30:0], 1'b0};
      OpSrl:   w_step = {1'b0, r_acc[31:1]};
      OpSar:   w_step = {r_acc[31], r_acc[31:1]};
      OpRotl:  w_step = {r_acc[30:0], r_acc[31]};
      OpRotr:  w_step = {r_acc[0], r_acc[31:1]};
      default: w_step = r_acc;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_count     <= '0;
      r_op        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_op       <= opcode;
            r_count    <= B[4:0];
            r_in_ready <= 1'b0;
            if (!w_op_valid) begin
              r_acc       <= '0;
              r_result    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else if (B[4:0] == 5'd0) begin
              r_acc       <= A;
              r_result    <= A;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_acc   <= A;
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          r_acc   <= w_step;
          r_count <= r_count - 5'd1;
          // The step applied with count=1 is the last one.
          if (r_count == 5'd1) begin
            r_result    <= w_step;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_result    <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_alu_shift_iter.sv
// Self-checking bench for alu_shift_iter using a result/latency scoreboard.
module tb_alu_shift_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int errors;
  int checks;

  logic [31:0] q_res[$];
  int          q_lat[$];

  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSar  = 4'b0110;
  localparam logic [3:0] OpRotl = 4'b0111;
  localparam logic [3:0] OpRotr = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;

  alu_shift_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: combinational definition of each operation.
  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    int unsigned s;
    logic signed [31:0] sa;
    s  = int'(b[4:0]);
    sa = a;
    case (op)
      OpSll:   model_res = a << s;
      OpSrl:   model_res = a >> s;
      OpSar:   model_res = sa >>> s;
      OpRotl:  model_res = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      OpRotr:  model_res = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: model_res = 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic [3:0] op);
    if (op inside {OpSll, OpSar, OpRotl, OpRotr, OpSrl}) model_lat = int'(b[4:0]) + 1;
    else model_lat = 1;
  endfunction

  // Present one request and push its expected outcome; returns just after acceptance edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    @(posedge clk);
    #1;
    A = a; B = b; opcode = op; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    q_res.push_back(model_res(a, b, op));
    q_lat.push_back(model_lat(b, op));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and compare against the scoreboard head.
  task automatic collect(input string name);
    int          cyc;
    bit          busy_bad;
    logic [31:0] er;
    int          el;
    cyc = 0;
    busy_bad = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) break;
      if (result !== 32'h0 || in_ready !== 1'b0) busy_bad = 1'b1;
    end
    checks++;
    if (q_res.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: output seen with empty queue", name);
      return;
    end
    er = q_res.pop_front();
    el = q_lat.pop_front();
    if (out_valid !== 1'b1 || cyc != el) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (out_valid=%b) expected %0d",
               name, cyc, out_valid, el);
    end
    checks++;
    if (result !== er) begin
      errors++;
      $display("FAIL %s_result: got %h expected %h", name, result, er);
    end
    checks++;
    if (busy_bad || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: result/in_ready wrong while busy (in_ready=%b) expected 0",
               name, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = 32'h0; B = 32'h0; opcode = 4'h0;
    #13;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b result=%h expected 0/0", out_valid, result);
    end
    // Release reset with a request already present: first edge must accept it.
    @(negedge clk);
    rst = 1'b0;
    A = 32'h0000_00F0; B = 32'd2; opcode = OpSrl; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
    q_res.push_back(32'h0000_003C);
    q_lat.push_back(3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("first_req");
  endtask

  task automatic test_vectors;
    logic [31:0] va[10] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
                            32'h8000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA5A5_A5A5,
                            32'hF000_0000, 32'h8765_4321};
    logic [31:0] vb[10] = '{32'd4, 32'd31, 32'd31, 32'd1, 32'd36, 32'd0, 32'd3, 32'd7,
                            32'h20, 32'hFFFF_FFE5};
    logic [3:0]  vo[10] = '{OpSll, OpSar, OpSrl, OpRotr, OpRotl, OpRotl, 4'b0000, 4'b1111,
                            OpSar, OpRotr};
    for (int i = 0; i < 10; i++) begin
      send(va[i], vb[i], vo[i]);
      collect($sformatf("vec%0d", i));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
        errors++;
        $display("FAIL vec%0d_idle: in_ready=%b out_valid=%b result=%h expected 1/0/0",
                 i, in_ready, out_valid, result);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(32'h1, 32'd2, OpSll);
    collect("bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      A = 32'hDEAD_BEEF; B = 32'd1; opcode = OpRotl; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h0000_0004 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b result=%h in_ready=%b expected 1/00000004/0",
                 i, out_valid, result, in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b result=%h expected 1/0/0",
               in_ready, out_valid, result);
    end
    // The requests offered during DONE must not have started anything.
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ignored: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    send(32'h8000_0000, 32'd20, OpSar);
    void'(q_res.pop_back());
    void'(q_lat.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b result=%h in_ready=%b expected 0/0/1",
               out_valid, result, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_abandon: stale output or busy after reset, expected idle");
    end
    send(32'h3, 32'd1, OpSll);
    collect("after_rst");
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    for (int i = 0; i < 12; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = (i % 3 == 2) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 9));
      send(a, b, op);
      collect($sformatf("b2b%0d", i));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (q_res.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q_res.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
